// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB-based dynamic branch predictor.
// Sweep-state enum, counter-threshold functions and PC index/tag extraction.
package bp_pkg;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_t;

    function automatic int unsigned weak_nt(input int unsigned ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int unsigned weak_t(input int unsigned ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    // PCs are word aligned, so bits [1:0] never take part in index or tag.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_bits);
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_bits,
                                           input int unsigned tag_bits);
        return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_table.sv
// BTB storage: async read ports for lookup and read-modify-write, one sync write port.
// The write port is shared between the init sweep and resolved-branch updates.
module bp_table #(
    parameter int ENTRIES = 64,
    parameter int W       = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             sweep_we,
    input  logic [IDX_W-1:0] sweep_idx,
    input  logic [W-1:0]     sweep_data,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [W-1:0]     upd_data,
    input  logic [IDX_W-1:0] lk_idx,
    output logic [W-1:0]     lk_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0]     mem [ENTRIES];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [W-1:0]     wr_data;

    // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        wr_en   = sweep_we | upd_we;
        wr_idx  = upd_idx;
        wr_data = upd_data;
        if (sweep_we) begin
            wr_idx  = sweep_idx;
            wr_data = sweep_data;
        end
    end

    // NOTE: the array has no reset so it maps onto distributed RAM; the init sweep clears it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign lk_data = mem[lk_idx];
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB predictor with saturating counters, an init sweep FSM
// and saturating lookup/mispredict performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 10,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              lk_valid,
    input  logic [XLEN-1:0]   lk_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    localparam int                  ENTRY_W   = $bits(entry_t);
    localparam logic [CTR_BITS-1:0] WEAK_NT_C = CTR_BITS'(weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WEAK_T_C  = CTR_BITS'(weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX_C = CTR_BITS'(ctr_max(CTR_BITS));

    bp_state_t        state, state_nxt;
    logic [IDX_W-1:0] sweep_idx;
    logic             sweep_we;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_idx == IDX_W'(ENTRIES - 1)) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        ready    = (state == RUN);
        sweep_we = (state == INIT);
    end

    logic [IDX_W-1:0]    lk_idx, upd_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    entry_t              lk_entry, upd_entry, upd_wdata, sweep_data;
    logic                lk_hit, upd_hit, upd_we;

    assign lk_idx  = IDX_W'(pc_idx(64'(lk_pc), IDX_W));
    assign lk_tag  = TAG_BITS'(pc_tag(64'(lk_pc), IDX_W, TAG_BITS));
    assign upd_idx = IDX_W'(pc_idx(64'(upd_pc), IDX_W));
    assign upd_tag = TAG_BITS'(pc_tag(64'(upd_pc), IDX_W, TAG_BITS));

    assign sweep_data = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT_C};

    bp_table #(
        .ENTRIES (ENTRIES),
        .W       (ENTRY_W)
    ) u_table (
        .clk        (clk),
        .sweep_we   (sweep_we),
        .sweep_idx  (sweep_idx),
        .sweep_data (sweep_data),
        .upd_we     (upd_we),
        .upd_idx    (upd_idx),
        .upd_data   (upd_wdata),
        .lk_idx     (lk_idx),
        .lk_data    (lk_entry),
        .rd_idx     (upd_idx),
        .rd_data    (upd_entry)
    );

    // Lookup reads the pre-update entry; a same-cycle update is seen only next cycle.
    assign lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign pred_taken  = ready && lk_valid && lk_hit && lk_entry.ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? lk_entry.target : '0;

    assign upd_hit = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        upd_we    = 1'b0;
        upd_wdata = upd_entry;
        if (ready && upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken) begin
                    upd_wdata.target = upd_target;
                    if (upd_entry.ctr != CTR_MAX_C) begin
                        upd_wdata.ctr = upd_entry.ctr + 1'b1;
                    end
                end else if (upd_entry.ctr != '0) begin
                    upd_wdata.ctr = upd_entry.ctr - 1'b1;
                end
            end else if (upd_taken) begin
                upd_we    = 1'b1;
                upd_wdata = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WEAK_T_C};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (ready && lk_valid && stat_lookups != '1) begin
                stat_lookups <= stat_lookups + 1'b1;
            end
            if (ready && upd_valid && upd_mispredict && stat_mispred != '1) begin
                stat_mispred <= stat_mispred + 1'b1;
            end
        end
    end

endmodule
